// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential shifter.
// SHIFT_ROTATE_EN makes ROL/ROR legal operations.
package shift_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
        return op <= 3'd4;
`else
        return op <= 3'd2;
`endif
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate of a data word for the selected op.
// Rotate paths exist only when SHIFT_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
(
    input  logic [2:0]    op,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_SLL:  q = {d[DW-2:0], 1'b0};
            OP_SRL:  q = {1'b0, d[DW-1:1]};
            OP_SRA:  q = {d[DW-1], d[DW-1:1]};
`ifdef SHIFT_ROTATE_EN
            OP_ROL:  q = {d[DW-2:0], d[DW-1]};
            OP_ROR:  q = {d[0], d[DW-1:1]};
`endif
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Bit-serial shifter: one bit per cycle, IDLE/SHIFT/DONE FSM.
// SHIFT_ROTATE_EN enables ROL/ROR; otherwise they report err.
module shift_seq_unit
    import shift_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [4:0]    shamt,
    input  logic [DW-1:0] data_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] data_out,
    output logic          err
);

    state_e        state;
    logic [2:0]    op_q;
    logic [4:0]    cnt;
    logic [DW-1:0] step;

    shift_step u_step (
        .op (op_q),
        .d  (data_out),
        .q  (step)
    );

    // Outputs are registered alongside the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            cnt      <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        data_out <= data_in;
                        op_q     <= op;
                        cnt      <= shamt;
                        if (shamt != 5'd0 && op_legal(op)) begin
                            state <= S_SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= ~op_legal(op);
                        end
                    end
                end
                S_SHIFT: begin
                    data_out <= step;
                    cnt      <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed self-checking bench for shift_seq_unit.
// Define SHIFT_ROTATE_EN to exercise the rotate ops.
module tb_shift_seq_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic        err;

    int checks;
    int errors;

    shift_seq_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation from IDLE; inputs are scrambled after capture.
    // lat counts sampled cycles after the start edge until done is seen.
    task automatic run_op(
        input  logic [2:0]  o,
        input  logic [4:0]  s,
        input  logic [31:0] d,
        output int          lat,
        output int          nbusy,
        output logic [31:0] res,
        output logic        e,
        output logic        done2,
        output logic [31:0] res2
    );
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        shamt   = s;
        data_in = d;
        @(negedge clk);
        start   = 1'b0;
        op      = o ^ 3'd1;
        shamt   = ~s;
        data_in = ~d;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        res = data_out;
        e   = err;
        @(negedge clk);
        done2 = done;
        res2  = data_out;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        shamt   = 5'd0;
        data_in = 32'h0;
        @(negedge clk);
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 00000000", data_out);
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000", {busy, done, err});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_sll();
        int lat, nb;
        logic [31:0] r, r2;
        logic e, d2;
        run_op(3'd0, 5'd4, 32'h0000_0001, lat, nb, r, e, d2, r2);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL sll_latency got %0d exp 5", lat);
        end
        checks++;
        if (nb !== 4) begin
            errors++;
            $display("FAIL sll_busy_cycles got %0d exp 4", nb);
        end
        checks++;
        if (r !== 32'h0000_0010 || e !== 1'b0) begin
            errors++;
            $display("FAIL sll_result got %h/%b exp 00000010/0", r, e);
        end
        checks++;
        if (d2 !== 1'b0 || r2 !== 32'h0000_0010) begin
            errors++;
            $display("FAIL sll_hold got %b/%h exp 0/00000010", d2, r2);
        end
    endtask

    task automatic test_sra_srl();
        int lat, nb;
        logic [31:0] r, r2;
        logic e, d2;
        run_op(3'd2, 5'd31, 32'h8000_0000, lat, nb, r, e, d2, r2);
        checks++;
        if (r !== 32'hFFFF_FFFF || nb !== 31 || lat !== 32) begin
            errors++;
            $display("FAIL sra31 got %h busy %0d lat %0d exp ffffffff 31 32",
                     r, nb, lat);
        end
        run_op(3'd1, 5'd31, 32'h8000_0000, lat, nb, r, e, d2, r2);
        checks++;
        if (r !== 32'h0000_0001 || nb !== 31 || e !== 1'b0) begin
            errors++;
            $display("FAIL srl31 got %h busy %0d err %b exp 00000001 31 0",
                     r, nb, e);
        end
        run_op(3'd2, 5'd3, 32'h4000_00F0, lat, nb, r, e, d2, r2);
        checks++;
        if (r !== 32'h0800_001E) begin
            errors++;
            $display("FAIL sra_pos got %h exp 0800001e", r);
        end
    endtask

    task automatic test_zero_shift();
        int lat, nb;
        logic [31:0] r, r2;
        logic e, d2;
        run_op(3'd1, 5'd0, 32'hDEAD_BEEF, lat, nb, r, e, d2, r2);
        checks++;
        if (lat !== 1 || nb !== 0) begin
            errors++;
            $display("FAIL zero_timing got lat %0d busy %0d exp 1 0", lat, nb);
        end
        checks++;
        if (r !== 32'hDEAD_BEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_result got %h/%b exp deadbeef/0", r, e);
        end
    endtask

    task automatic test_illegal();
        int lat, nb;
        logic [31:0] r, r2;
        logic e, d2;
        run_op(3'd6, 5'd5, 32'h1234_5678, lat, nb, r, e, d2, r2);
        checks++;
        if (r !== 32'h1234_5678 || e !== 1'b1 || nb !== 0 || lat !== 1) begin
            errors++;
            $display("FAIL illegal6 got %h err %b busy %0d lat %0d",
                     r, e, nb, lat);
        end
        checks++;
        if (err !== 1'b0 || d2 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err_clear got %b/%b exp 0/0", err, d2);
        end
`ifdef SHIFT_ROTATE_EN
        run_op(3'd3, 5'd1, 32'h8000_0001, lat, nb, r, e, d2, r2);
        checks++;
        if (r !== 32'h0000_0003 || e !== 1'b0) begin
            errors++;
            $display("FAIL rol1 got %h/%b exp 00000003/0", r, e);
        end
        run_op(3'd4, 5'd4, 32'h0000_00A5, lat, nb, r, e, d2, r2);
        checks++;
        if (r !== 32'h5000_000A || e !== 1'b0) begin
            errors++;
            $display("FAIL ror4 got %h/%b exp 5000000a/0", r, e);
        end
`else
        run_op(3'd3, 5'd1, 32'h1234_5678, lat, nb, r, e, d2, r2);
        checks++;
        if (r !== 32'h1234_5678 || e !== 1'b1 || nb !== 0) begin
            errors++;
            $display("FAIL rol_illegal got %h err %b busy %0d", r, e, nb);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start   = 1'b1;
        op      = 3'd0;
        shamt   = 5'd2;
        data_in = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        start   = 1'b1;
        data_in = 32'h0000_AAAA;
        shamt   = 5'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0000_000C) begin
            errors++;
            $display("FAIL start_in_done got %b%b %h exp 00 0000000c",
                     busy, done, data_out);
        end
    endtask

    task automatic test_reset_abort();
        int dseen;
        @(negedge clk);
        start   = 1'b1;
        op      = 3'd1;
        shamt   = 5'd8;
        data_in = 32'hFF00_0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start   = 1'b1;
        op      = 3'd0;
        shamt   = 5'd2;
        data_in = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (data_out !== 32'h1FE0_0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy_start got %h/%b exp 1fe00000/1",
                     data_out, busy);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 32'h0 || {busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got %h %b exp 00000000 000",
                     data_out, {busy, done, err});
        end
        dseen = 0;
        @(negedge clk);
        if (done) dseen++;
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dseen++;
        end
        checks++;
        if (dseen !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d exp 0", dseen);
        end
    endtask

    task automatic test_after_reset();
        int lat, nb;
        logic [31:0] r, r2;
        logic e, d2;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op(3'd0, 5'd1, 32'h0000_0001, lat, nb, r, e, d2, r2);
        checks++;
        if (r !== 32'h0000_0002 || lat !== 2 || nb !== 1) begin
            errors++;
            $display("FAIL first_after_reset got %h lat %0d busy %0d exp 2 2 1",
                     r, lat, nb);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sll();
        test_sra_srl();
        test_zero_shift();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        test_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR; 5-7 illegal.
REQ-006 shamt  input  5  shift amount, 0-31.
REQ-007 data_in  input  32  operand; driven by the shift-source select mux output.
REQ-008 busy  output  1  high in SHIFT state.
REQ-009 done  output  1  one-cycle pulse when the result is final.
REQ-010 data_out  output  32  result register.
REQ-011 err  output  1  high with done when the captured op was illegal.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture data_in into data_out, op, and shamt into a 5-bit counter.
- Next state SHALL be SHIFT if shamt!=0 and op is legal, else DONE.
REQ-014 Each SHIFT cycle SHALL shift data_out by exactly one bit and decrement the counter.
- SLL: zero fill on the right.
- SRL: zero fill on the left.
- SRA: fill with bit 31.
- ROL/ROR: wrap the bit around.
REQ-015 SHIFT SHALL go to DONE in the cycle the counter reaches 0 after decrement.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-017 Latency SHALL be: start sampled at edge t -> done high in the cycle after edge t+shamt+1 for shamt>=1; done high in the cycle after edge t+1 for shamt=0.
REQ-018 For shamt=0, data_out SHALL equal data_in unchanged.
REQ-019 data_out SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-020 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-021 For an illegal op, data_out SHALL equal data_in, no shifting SHALL occur, and err=1 during the DONE cycle.
REQ-022 err SHALL be 0 at all other times.
REQ-023 Changes on op, shamt or data_in after capture SHALL NOT affect the operation in progress.

Reset
REQ-024 While reset_n=0, the block SHALL hold: state IDLE, data_out=0, counter=0, busy=0, done=0, err=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation immediately, with no done pulse.
REQ-026 After reset release, the first edge SHALL be able to accept start.

Configuration
REQ-027 The macro SHIFT_ROTATE_EN SHALL select whether rotate support is compiled in.
- Defined: ROL/ROR are legal and rotate.
- Undefined: ROL/ROR SHALL be treated as illegal per REQ-021, and no rotate datapath SHALL be synthesised.

Structure
REQ-028 Op encodings, the state enumeration and the 32-bit data width constant SHALL live in shared package shift_pkg.
REQ-029 One combinational sub-module, shift_step, SHALL compute the single-bit shift of 32-bit data for a given op.
- The FSM/counter logic SHALL stay in shift_seq_unit.

Verification
REQ-030 SLL: data_in=0x0000_0001, shamt=4, start -> busy for 4 cycles, done pulse, data_out=0x0000_0010, err=0.
REQ-031 SRA: data_in=0x8000_0000, shamt=31 -> data_out=0xFFFF_FFFF after 31 SHIFT cycles; with op SRL -> data_out=0x0000_0001.
REQ-032 shamt=0 and op=SRL on 0xDEAD_BEEF -> done one cycle after start, data_out=0xDEAD_BEEF, busy never high.
REQ-033 Illegal op (op=6 always; op=3 without SHIFT_ROTATE_EN) on 0x1234_5678 -> done with err=1, data_out=0x1234_5678.
- With SHIFT_ROTATE_EN, ROL 0x8000_0001 by 1 -> 0x0000_0003.
REQ-034 Start SRL by 8 on 0xFF00_0000, pulse start again in cycle 3 with new data, assert reset_n=0 in cycle 5 -> second start ignored, outputs zero immediately on reset, no done pulse.
